// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the UART TX FIFO push port: grants one source per whole
// message, forwards its bytes while the FIFO has room, then optionally adds CR/LF.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter bit APPEND_CRLF = 1'b1,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic [NUM_REQ-1:0]   iReq,
  input  logic [8*NUM_REQ-1:0] iData,
  input  logic [NUM_REQ-1:0]   iLast,
  output logic [NUM_REQ-1:0]   oGrant,
  output logic [NUM_REQ-1:0]   oPop,
  output logic                 oTx_Push,
  output logic [7:0]           oTx_Data,
  input  logic                 iTx_Full,
  output logic                 oBusy,
  output logic                 oAbort
);

  localparam int            IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int            CW       = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [IW:0]   NUM_W    = (IW+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_CR   = 2'd2,
    S_LF   = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt, w_done_state;
  logic [IW-1:0]      r_g, w_g_nxt;
  logic [IW-1:0]      r_rr, w_rr_nxt;
  logic [IW-1:0]      w_g_inc, w_off, w_sel;
  logic [IW:0]        w_sum;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0] w_grant_oh, w_rot;
  logic               w_req_g, w_last_g;
  logic [7:0]         w_data_g;

  assign w_done_state = APPEND_CRLF ? S_CR : S_IDLE;
  assign w_g_inc      = (r_g == IW'(NUM_REQ - 1)) ? {IW{1'b0}} : r_g + IW'(1);
  assign oBusy        = (r_state != S_IDLE);
  assign oGrant       = oBusy ? w_grant_oh : {NUM_REQ{1'b0}};

  // Rotate requests so bit 0 is the rr position; the lowest set bit wins.
  always_comb begin
    w_rot = NUM_REQ'({iReq, iReq} >> r_rr);
    w_off = {IW{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_off = w_rot[k] ? IW'(k) : w_off;
    end
    w_sum = {1'b0, r_rr} + {1'b0, w_off};
    w_sel = (w_sum >= NUM_W) ? IW'(w_sum - NUM_W) : IW'(w_sum);
  end

  always_comb begin
    w_grant_oh = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      w_grant_oh[i] = (r_g == IW'(i));
    end
  end

  always_comb begin
    w_req_g  = 1'b0;
    w_last_g = 1'b0;
    w_data_g = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_req_g  = w_req_g  | (iReq[i]  & w_grant_oh[i]);
      w_last_g = w_last_g | (iLast[i] & w_grant_oh[i]);
      w_data_g = w_data_g | (iData[8*i +: 8] & {8{w_grant_oh[i]}});
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_g_nxt     = r_g;
    w_rr_nxt    = r_rr;
    w_cnt_nxt   = r_cnt;
    oTx_Push    = 1'b0;
    oTx_Data    = 8'h00;
    oPop        = {NUM_REQ{1'b0}};
    oAbort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = {CW{1'b0}};
        if (|iReq) begin
          w_g_nxt     = w_sel;
          w_state_nxt = S_SEND;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SEND: begin
        if (w_req_g && !iTx_Full) begin
          oTx_Push  = 1'b1;
          oTx_Data  = w_data_g;
          oPop      = w_grant_oh;
          w_cnt_nxt = {CW{1'b0}};
          if (w_last_g) begin
            w_state_nxt = w_done_state;
            w_rr_nxt    = w_g_inc;
          end else begin
            w_state_nxt = S_SEND;
          end
        end else if (!w_req_g) begin
          // Source stall counts toward the abort; FIFO back-pressure does not.
          if (r_cnt == CNT_LAST) begin
            oAbort      = 1'b1;
            w_state_nxt = w_done_state;
            w_rr_nxt    = w_g_inc;
            w_cnt_nxt   = {CW{1'b0}};
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      S_CR: begin
        if (!iTx_Full) begin
          oTx_Push    = 1'b1;
          oTx_Data    = 8'h0D;
          w_state_nxt = S_LF;
        end else begin
          w_state_nxt = S_CR;
        end
      end
      S_LF: begin
        if (!iTx_Full) begin
          oTx_Push    = 1'b1;
          oTx_Data    = 8'h0A;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_LF;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_state <= S_IDLE;
      r_g     <= {IW{1'b0}};
      r_rr    <= {IW{1'b0}};
      r_cnt   <= {CW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_g     <= w_g_nxt;
      r_rr    <= w_rr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-source byte queues drive the DUT and a
// message-level round-robin scheduler predicts the exact FIFO byte stream.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [7:0]   dat;
    logic [N-1:0] pop;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req, last, grant, pop;
  logic [8*N-1:0] data;
  logic           push, full, busy, abort;
  logic [7:0]     txd;
  logic [N-1:0]   req2, last2, grant2, pop2;
  logic [8*N-1:0] data2;
  logic           push2, full2, busy2, abort2;
  logic [7:0]     txd2;

  int n_vec = 0;
  int n_err = 0;
  int cyc, mdl_rr, abort_cnt, abort_cyc, first_grant_cyc, nst, k;
  int grant_cyc[N];
  int pop_cnt[N];
  logic [N-1:0] pop_seen;
  bit force_full, rand_full;
  int   push_cyc_q[$];
  logic [7:0] push_dat_q[$];
  logic [8:0] src_q[N][$];
  logic [7:0] mdl_b[N][$];
  int   mdl_len[N][$];
  exp_t exp_q[$];

  uart_tx_arbiter #(.NUM_REQ(N), .APPEND_CRLF(1'b1), .TIMEOUT_CYC(8)) dut (
    .iClk(clk), .iRst(rst_n), .iReq(req), .iData(data), .iLast(last),
    .oGrant(grant), .oPop(pop), .oTx_Push(push), .oTx_Data(txd),
    .iTx_Full(full), .oBusy(busy), .oAbort(abort)
  );

  uart_tx_arbiter #(.NUM_REQ(N), .APPEND_CRLF(1'b0), .TIMEOUT_CYC(8)) dut2 (
    .iClk(clk), .iRst(rst_n), .iReq(req2), .iData(data2), .iLast(last2),
    .oGrant(grant2), .oPop(pop2), .oTx_Push(push2), .oTx_Data(txd2),
    .iTx_Full(full2), .oBusy(busy2), .oAbort(abort2)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int pc(input int i);
    return (i < push_cyc_q.size()) ? push_cyc_q[i] : -1;
  endfunction

  function automatic int pd(input int i);
    return (i < push_dat_q.size()) ? int'(push_dat_q[i]) : -1;
  endfunction

  function automatic bit srcs_empty();
    bit e = 1'b1;
    for (int i = 0; i < N; i++) e &= (src_q[i].size() == 0);
    return e;
  endfunction

  task automatic clr_stats();
    for (int i = 0; i < N; i++) begin
      grant_cyc[i] = 0;
      pop_cnt[i]   = 0;
    end
    abort_cnt = 0;
    abort_cyc = -1;
    first_grant_cyc = -1;
    push_cyc_q.delete();
    push_dat_q.delete();
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]          = (src_q[i].size() > 0);
      last[i]         = (src_q[i].size() > 0) ? src_q[i][0][8] : 1'b0;
      data[8*i +: 8]  = (src_q[i].size() > 0) ? src_q[i][0][7:0] : 8'h00;
    end
    full = force_full | (rand_full && ($urandom_range(0, 99) < 30));
  endtask

  task automatic monitor();
    exp_t e;
    chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_cyc[i]++;
      if (pop[i]) pop_cnt[i]++;
    end
    if (grant != '0 && first_grant_cyc < 0) first_grant_cyc = cyc;
    pop_seen = pop;
    if (abort) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
    if (push) begin
      chk("push_while_full", 32'(full), 32'd0);
      chk("push_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tx_data", 32'(txd), 32'(e.dat));
        chk("pop_owner", 32'(pop), 32'(e.pop));
      end
      push_cyc_q.push_back(cyc);
      push_dat_q.push_back(txd);
    end else begin
      chk("quiet_data", 32'(txd), 32'd0);
      chk("quiet_pop", 32'(pop), 32'd0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (pop_seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    drive();
  endtask

  task automatic enq(input int s, input int n, input bit trunc, input int base);
    logic [7:0] b;
    for (int j = 0; j < n; j++) begin
      b = (base < 0) ? 8'($urandom_range(0, 255)) : 8'(base + j);
      src_q[s].push_back({1'((j == n - 1) && !trunc), b});
      mdl_b[s].push_back(b);
    end
    mdl_len[s].push_back(n);
  endtask

  // Whole-message scheduler: next owner is the first source with a pending
  // message at or after rr; each message (complete or aborted) ends in CR/LF.
  task automatic model_run();
    int s, n;
    exp_t e;
    for (int guard = 0; guard < 256; guard++) begin
      s = -1;
      for (int j = N - 1; j >= 0; j--) begin
        if (mdl_len[(mdl_rr + j) % N].size() > 0) s = (mdl_rr + j) % N;
      end
      if (s < 0) break;
      n = mdl_len[s].pop_front();
      for (int j = 0; j < n; j++) begin
        e.dat = mdl_b[s].pop_front();
        e.pop = N'(1) << s;
        exp_q.push_back(e);
      end
      e.pop = '0;
      e.dat = 8'h0D;
      exp_q.push_back(e);
      e.dat = 8'h0A;
      exp_q.push_back(e);
      mdl_rr = (s + 1) % N;
    end
    drive();
  endtask

  task automatic run_idle(input int max);
    int j = 0;
    while (j < max && !(exp_q.size() == 0 && srcs_empty() && !busy)) begin
      tick();
      j++;
    end
    chk("drain_in_time", 32'(j < max), 32'd1);
    chk("stream_consumed", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; force_full = 1'b0; rand_full = 1'b0;
    req = '0; last = '0; data = '0; full = 1'b0;
    req2 = '0; last2 = '0; data2 = '0; full2 = 1'b0;
    cyc = 0; mdl_rr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_pop", 32'(pop), 32'd0);
    chk("rst_push", 32'(push), 32'd0);
    chk("rst_data", 32'(txd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    chk("rst2_grant", 32'(grant2), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contention from rr = 0, then sources 0 and 3 together with rr back at 0
    clr_stats();
    for (int s = 0; s < N; s++) enq(s, 2, 1'b0, 8'h40 + 16 * s);
    model_run();
    run_idle(200);
    for (int s = 0; s < N; s++) chk("cont_grant_cycles", 32'(grant_cyc[s]), 32'd4);
    chk("cont_first", 32'(pd(0)), 32'h40);
    chk("cont_push_count", 32'(push_cyc_q.size()), 32'd16);
    clr_stats();
    enq(0, 2, 1'b0, 8'hA0);
    enq(3, 2, 1'b0, 8'hB3);
    model_run();
    run_idle(100);
    chk("rr0_first_src0", 32'(pd(0)), 32'hA0);

    // Single source 2 sends "123"
    clr_stats();
    nst = cyc;
    enq(2, 3, 1'b0, 8'h31);
    model_run();
    run_idle(50);
    chk("single_first_grant", 32'(first_grant_cyc), 32'(nst + 1));
    chk("single_first_push", 32'(pc(0)), 32'(nst + 1));
    chk("single_push_span", 32'(pc(4) - pc(0)), 32'd4);
    chk("single_push_count", 32'(push_cyc_q.size()), 32'd5);
    chk("single_pops", 32'(pop_cnt[2]), 32'd3);
    chk("single_grant_cycles", 32'(grant_cyc[2]), 32'd5);
    chk("single_idle_after", 32'(busy), 32'd0);

    // rr now points at 3: source 3 wins against source 0
    clr_stats();
    enq(0, 2, 1'b0, 8'hA0);
    enq(3, 2, 1'b0, 8'hB3);
    model_run();
    run_idle(100);
    chk("rr3_first_src3", 32'(pd(0)), 32'hB3);

    // Back-pressure for 20 cycles mid-message
    clr_stats();
    enq(1, 6, 1'b0, 8'h61);
    model_run();
    k = 0;
    while (push_cyc_q.size() < 2 && k < 50) begin
      tick();
      k++;
    end
    chk("bp_reached", 32'(push_cyc_q.size()), 32'd2);
    force_full = 1'b1;
    drive();
    repeat (20) tick();
    chk("bp_no_push", 32'(push_cyc_q.size()), 32'd2);
    force_full = 1'b0;
    drive();
    tick();
    chk("bp_resume", 32'(pc(2)), 32'(cyc - 1));
    run_idle(50);
    chk("bp_no_abort", 32'(abort_cnt), 32'd0);
    chk("bp_pops", 32'(pop_cnt[1]), 32'd6);

    // Stall timeout: one byte from source 1 then iReq drops
    clr_stats();
    enq(1, 1, 1'b1, 8'h70);
    model_run();
    run_idle(100);
    chk("to_abort_count", 32'(abort_cnt), 32'd1);
    chk("to_abort_delay", 32'(abort_cyc - pc(0)), 32'd8);
    chk("to_cr_cycle", 32'(pc(1)), 32'(abort_cyc + 1));
    chk("to_lf_cycle", 32'(pc(2)), 32'(abort_cyc + 2));
    clr_stats();
    enq(1, 1, 1'b0, 8'h11);
    enq(2, 1, 1'b0, 8'h22);
    model_run();
    run_idle(50);
    chk("to_rr_is_2", 32'(pd(0)), 32'h22);

    // Randomised batches with random FIFO back-pressure
    rand_full = 1'b1;
    for (int b = 0; b < 8; b++) begin
      clr_stats();
      for (int s = 0; s < N; s++) begin
        if ($urandom_range(0, 1) == 1 || s == b % N) begin
          enq(s, $urandom_range(1, 6), 1'b0, -1);
          if ($urandom_range(0, 2) == 0) enq(s, $urandom_range(1, 6), 1'b0, -1);
        end
      end
      model_run();
      run_idle(1000);
    end
    rand_full = 1'b0;
    drive();

    // Reset during byte 2 of 5
    clr_stats();
    enq(0, 5, 1'b0, 8'hC0);
    model_run();
    k = 0;
    while (push_cyc_q.size() < 1 && k < 20) begin
      tick();
      k++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_pop", 32'(pop), 32'd0);
    chk("mid_rst_push", 32'(push), 32'd0);
    chk("mid_rst_data", 32'(txd), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_abort", 32'(abort), 32'd0);
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      mdl_b[i].delete();
      mdl_len[i].delete();
    end
    exp_q.delete();
    mdl_rr = 0;
    drive();
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    clr_stats();
    nst = cyc;
    enq(3, 1, 1'b0, 8'hD3);
    model_run();
    run_idle(20);
    chk("post_rst_grant", 32'(first_grant_cyc), 32'(nst + 1));
    chk("post_rst_push", 32'(pc(0)), 32'(nst + 1));
    chk("post_rst_data", 32'(pd(0)), 32'hD3);

    // No CR/LF: single-byte message from source 0
    @(posedge clk);
    #1;
    req2 = 4'b0001;
    last2 = 4'b0001;
    data2[7:0] = 8'h5A;
    #1;
    chk("nocrlf_idle_grant", 32'(grant2), 32'd0);
    chk("nocrlf_idle_push", 32'(push2), 32'd0);
    @(posedge clk);
    #1;
    chk("nocrlf_grant", 32'(grant2), 32'h1);
    chk("nocrlf_push", 32'(push2), 32'd1);
    chk("nocrlf_data", 32'(txd2), 32'h5A);
    chk("nocrlf_pop", 32'(pop2), 32'h1);
    @(posedge clk);
    #1;
    req2 = '0;
    last2 = '0;
    data2 = '0;
    #1;
    chk("nocrlf_after_grant", 32'(grant2), 32'd0);
    chk("nocrlf_after_push", 32'(push2), 32'd0);
    chk("nocrlf_after_busy", 32'(busy2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
